// File: rtl/wb_cmd_master_if.sv
// Command/response handshake plus Wishbone B4 classic master signals for wb_cmd_master.
// The master modport is the block's view; slave is the environment side.
interface wb_cmd_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_adr;
  logic [31:0] req_wdata;
  logic [3:0]  req_sel;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    input  req_valid, req_we, req_adr, req_wdata, req_sel, rsp_ready,
    input  wb_dat_i, wb_ack_i, wb_err_i,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );

  modport slave (
    output req_valid, req_we, req_adr, req_wdata, req_sel, rsp_ready,
    output wb_dat_i, wb_ack_i, wb_err_i,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-outstanding command to Wishbone B4 classic master with wait-cycle timeout.
// One command is carried on the bus at a time; its response is held until consumed.
module wb_cmd_master #(
  parameter int TIMEOUT = 64
) (
  input logic             clk,
  input logic             rst_n,
  wb_cmd_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic        cyc_reg;
  logic        we_reg;
  logic [31:0] adr_reg;
  logic [31:0] dat_reg;
  logic [3:0]  sel_reg;
  logic [7:0]  wait_cnt_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;
  logic        timeout_reg;

  logic        req_ready;
  logic        rsp_valid;
  logic        accept;
  logic        bus_ack;
  logic        bus_err;
  logic        bus_timeout;
  logic        bus_done;

  // Bus events only count while in BUS, so ack/err seen with cyc low are ignored.
  assign accept      = bus.req_valid && req_ready;
  assign bus_err     = (state_reg == BUS) && bus.wb_err_i;
  assign bus_ack     = (state_reg == BUS) && bus.wb_ack_i && !bus.wb_err_i;
  assign bus_timeout = (state_reg == BUS) && !bus.wb_ack_i && !bus.wb_err_i &&
                       (wait_cnt_reg == 8'(TIMEOUT));
  assign bus_done    = bus_ack || bus_err || bus_timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = BUS;
      BUS:     if (bus_done) state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_reg)
      IDLE:    req_ready = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
      end
    endcase
  end

  // Wishbone request side: captured on acceptance, held until the next one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_reg      <= 1'b0;
      we_reg       <= 1'b0;
      adr_reg      <= '0;
      dat_reg      <= '0;
      sel_reg      <= '0;
      wait_cnt_reg <= '0;
    end else begin
      if (accept) begin
        cyc_reg      <= 1'b1;
        we_reg       <= bus.req_we;
        adr_reg      <= bus.req_adr;
        dat_reg      <= bus.req_wdata;
        sel_reg      <= bus.req_sel;
        wait_cnt_reg <= 8'd1;
      end else if (bus_done) begin
        cyc_reg      <= 1'b0;
      end else if (state_reg == BUS) begin
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      if (bus_err) begin
        rdata_reg   <= '0;
        err_reg     <= 1'b1;
        timeout_reg <= 1'b0;
      end else if (bus_ack) begin
        rdata_reg   <= we_reg ? 32'd0 : bus.wb_dat_i;
        err_reg     <= 1'b0;
        timeout_reg <= 1'b0;
      end else if (bus_timeout) begin
        rdata_reg   <= '0;
        err_reg     <= 1'b1;
        timeout_reg <= 1'b1;
      end
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_rdata   = rdata_reg;
  assign bus.rsp_err     = err_reg;
  assign bus.rsp_timeout = timeout_reg;
  assign bus.wb_cyc_o    = cyc_reg;
  assign bus.wb_stb_o    = cyc_reg;
  assign bus.wb_we_o     = we_reg;
  assign bus.wb_adr_o    = adr_reg;
  assign bus.wb_dat_o    = dat_reg;
  assign bus.wb_sel_o    = sel_reg;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master: a planned slave behaviour per command yields the
// expected response, which a separate monitor compares when the DUT presents it.
module tb_wb_cmd_master;
  localparam int TO = 4;
  localparam int K_ACK = 0, K_ERR = 1, K_BOTH = 2, K_NONE = 3;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          w;
    int          kind;
    logic [31:0] data;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          cycs;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc_n = 0;
  int   rsp_n = 0;
  int   bp_req = 0;
  int   bp_done = 0;
  int   bp_left = 0;

  plan_t slave_q[$];
  exp_t  exp_q[$];
  int    acc_q[$];

  wb_cmd_master_if bus ();

  wb_cmd_master #(.TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at cycle %0d", name, act, want, cyc_n);
    end
  endtask

  // Reference: response follows from how the slave is planned to behave.
  function automatic exp_t model(input plan_t p);
    exp_t e;
    if (p.kind == K_NONE || p.w + 1 > TO) begin
      e.rdata = 0; e.err = 1; e.tmo = 1; e.cycs = TO;
    end else if (p.kind == K_ERR || p.kind == K_BOTH) begin
      e.rdata = 0; e.err = 1; e.tmo = 0; e.cycs = p.w + 1;
    end else begin
      e.rdata = p.we ? 32'd0 : p.data; e.err = 0; e.tmo = 0; e.cycs = p.w + 1;
    end
    e.lat = e.cycs + 1;
    return e;
  endfunction

  task automatic send(input plan_t p, input bit expect_rsp);
    int n;
    slave_q.push_back(p);
    if (expect_rsp) exp_q.push_back(model(p));
    bus.req_valid = 1'b1;
    bus.req_we    = p.we;
    bus.req_adr   = p.adr;
    bus.req_wdata = p.wdata;
    bus.req_sel   = p.sel;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.req_ready) break;
      n++;
      if (n > 200) begin
        bad++; total++;
        $display("FAIL accept_timeout: req_ready stuck low got=0 want=1");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "no acceptance");
      end
    end
    @(posedge clk);
    #1;
    if (expect_rsp) acc_q.push_back(cyc_n);
    bus.req_valid = 1'b0;
    bus.req_adr   = $urandom;
    bus.req_wdata = $urandom;
  endtask

  function automatic plan_t mk(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                               input logic [3:0] sel, input int w, input int kind,
                               input logic [31:0] data);
    plan_t p;
    p.we = we; p.adr = adr; p.wdata = wdata; p.sel = sel; p.w = w; p.kind = kind; p.data = data;
    return p;
  endfunction

  // Slave: drives its response at negedge, counting cycles with cyc high.
  plan_t cur;
  bit    s_active = 1'b0;
  int    s_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      s_active = 1'b0; s_cnt = 0;
      bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_dat_i = '0;
    end else if (bus.wb_cyc_o) begin
      if (!s_active) begin
        if (slave_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unplanned_cycle: got=cyc want=idle");
          cur = mk(0, 0, 0, 0, 0, K_NONE, 0);
        end else begin
          cur = slave_q.pop_front();
        end
        s_active = 1'b1; s_cnt = 0;
      end
      chk("wb_stb", bus.wb_stb_o, 1'b1);
      chk("wb_we", bus.wb_we_o, cur.we);
      chk("wb_adr", bus.wb_adr_o, cur.adr);
      chk("wb_dat_o", bus.wb_dat_o, cur.wdata);
      chk("wb_sel", bus.wb_sel_o, cur.sel);
      s_cnt++;
      if (cur.kind != K_NONE && s_cnt == cur.w + 1) begin
        bus.wb_ack_i = (cur.kind == K_ACK || cur.kind == K_BOTH);
        bus.wb_err_i = (cur.kind == K_ERR || cur.kind == K_BOTH);
        bus.wb_dat_i = (cur.kind == K_ACK) ? cur.data : $urandom;
      end else begin
        bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_dat_i = $urandom;
      end
    end else begin
      // Stray ack/err with cyc low must have no effect.
      s_active = 1'b0;
      bus.wb_ack_i = ($urandom_range(0, 5) == 0);
      bus.wb_err_i = ($urandom_range(0, 5) == 0);
      bus.wb_dat_i = $urandom;
    end
  end

  always @(posedge clk) begin
    #1;
    if (bp_req != bp_done && bus.rsp_valid) begin
      bp_left = 5;
      bp_done = bp_req;
    end
    if (!rst_n) begin
      bus.rsp_ready = 1'b0;
    end else if (bp_left > 0) begin
      bus.rsp_ready = 1'b0;
      bp_left--;
    end else begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the expected response on the first cycle rsp_valid is seen.
  bit          m_active = 1'b0;
  int          cyc_cnt = 0;
  logic [31:0] s_rdata;
  logic        s_err, s_tmo;
  always @(negedge clk) begin
    exp_t e;
    int a;
    if (!rst_n) begin
      m_active = 1'b0; cyc_cnt = 0;
    end else begin
      if (bus.wb_cyc_o) begin
        cyc_cnt++;
        chk("req_ready_in_bus", bus.req_ready, 1'b0);
      end
      if (bus.rsp_valid) begin
        chk("req_ready_in_resp", bus.req_ready, 1'b0);
        chk("cyc_in_resp", bus.wb_cyc_o, 1'b0);
        if (!m_active) begin
          if (exp_q.size() == 0 || acc_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rsp: got=rsp_valid want=none");
          end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            rsp_n++;
            $display("rsp %0d: rdata=%h err=%b tmo=%b cyc_cycles=%0d latency=%0d",
                     rsp_n, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout, cyc_cnt, cyc_n - a + 1);
            chk("rsp_rdata", bus.rsp_rdata, e.rdata);
            chk("rsp_err", bus.rsp_err, e.err);
            chk("rsp_timeout", bus.rsp_timeout, e.tmo);
            chk("cyc_cycles", cyc_cnt, e.cycs);
            chk("latency", cyc_n - a + 1, e.lat);
          end
          s_rdata = bus.rsp_rdata; s_err = bus.rsp_err; s_tmo = bus.rsp_timeout;
          cyc_cnt = 0;
          m_active = 1'b1;
        end else begin
          chk("hold_rdata", bus.rsp_rdata, s_rdata);
          chk("hold_err", bus.rsp_err, s_err);
          chk("hold_timeout", bus.rsp_timeout, s_tmo);
        end
        if (bus.rsp_ready) m_active = 1'b0;
      end
    end
  end

  initial begin
    plan_t p;
    int n;
    bus.req_valid = 0; bus.req_we = 0; bus.req_adr = 0; bus.req_wdata = 0; bus.req_sel = 0;
    bus.rsp_ready = 0; bus.wb_dat_i = 0; bus.wb_ack_i = 0; bus.wb_err_i = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_cyc", bus.wb_cyc_o, 1'b0);
    chk("rst_stb", bus.wb_stb_o, 1'b0);
    chk("rst_we", bus.wb_we_o, 1'b0);
    chk("rst_adr", bus.wb_adr_o, 32'd0);
    chk("rst_dat", bus.wb_dat_o, 32'd0);
    chk("rst_sel", bus.wb_sel_o, 4'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_err", bus.rsp_err, 1'b0);
    chk("rst_timeout", bus.rsp_timeout, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed: 2-wait read, zero-wait write, ack+err, silent slave.
    send(mk(0, 32'h1000, 32'h0, 4'hF, 2, K_ACK, 32'hDEADBEEF), 1);
    send(mk(1, 32'h2004, 32'h12345678, 4'hC, 0, K_ACK, 32'hA5A5A5A5), 1);
    send(mk(0, 32'h3000, 32'h0, 4'hF, 1, K_BOTH, 32'h11111111), 1);
    send(mk(0, 32'h4000, 32'h0, 4'h3, 0, K_NONE, 32'h0), 1);

    // Backpressure: consumer stalls 5 cycles while the next command waits.
    bp_req++;
    send(mk(0, 32'h5000, 32'h0, 4'hF, 0, K_ACK, 32'hCAFEF00D), 1);
    send(mk(1, 32'h5004, 32'h87654321, 4'h1, 1, K_ACK, 32'h0), 1);

    // Reset mid-BUS abandons the command without a response.
    send(mk(0, 32'h6000, 32'h0, 4'hF, 0, K_NONE, 32'h0), 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("cyc_after_reset", bus.wb_cyc_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("no_rsp_after_reset", bus.rsp_valid, 1'b0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    send(mk(0, 32'h7000, 32'h0, 4'hF, 1, K_ACK, 32'h600DD00D), 1);

    // Randomised traffic.
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 9);
      p = mk($urandom_range(0, 1), {$urandom_range(0, 32'h3FFF), 2'b00}, $urandom,
             4'($urandom_range(0, 15)), $urandom_range(0, 5),
             (r < 6) ? K_ACK : (r == 6) ? K_ERR : (r == 7) ? K_BOTH : K_NONE, $urandom);
      send(p, 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    n = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid) && n < 500) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d pending want=0", exp_q.size());
    end
    repeat (4) @(negedge clk);
    chk("final_idle_ready", bus.req_ready, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
